gated_clk_en_ctrl: RTL and testbench
====================================

// Module: gated_clk_en_ctrl
// PURPOSE
//  Idle-detect controller that generates the CE input of a BUFGCE clock-gate cell.
//  Monitors activity sources of one gated clock domain and drops clk_en after a
//  programmable run of idle cycles. Re-enables on wake request, activity, scan force or cfg.
//  Reports domain readiness to requesters once the woken clock has settled.
//  Runs on the free-running clock, upstream of the gate cell.
// PARAMETERS
//  NUM_SRC      4  number of busy_in activity sources
//  IDLE_CNT_W   4  idle/wake counter width; >= clog2(max(IDLE_THRESH,WAKE_DLY)+1)
//  IDLE_THRESH  8  consecutive idle cycles before gating; >= 1
//  WAKE_DLY     2  cycles after clk_en rises before gclk_ready asserts; >= 1
// PORTS
//  forever_cpuclk  in   1        free-running (ungated) clock
//  cpurst          in   1        async reset, active-high
//  busy_in         in   NUM_SRC  per-source activity, high = busy
//  wake_req        in   1        wake request, level or single-cycle pulse
//  icg_force_on    in   1        scan/debug force, clock always on
//  cfg_gate_en     in   1        1 = gating allowed, 0 = never gate
//  clk_en          out  1        to BUFGCE CE: clk_en_q | icg_force_on
//  gclk_ready      out  1        gated domain clocking and settled
//  gate_state      out  2        00 RUN, 01 OFF, 10 WAKE (11 unused)
// BEHAVIOUR
//  - active = |busy_in | wake_req | icg_force_on | ~cfg_gate_en; all sampled on clk rise.
//  - Reset (async, any state) -> state RUN, cnt 0, clk_en_q 1, gclk_ready 1, gate_state 00.
//    The gated domain clocks out of reset.
//  - RUN: clk_en_q=1, gclk_ready=1.
//      active            -> cnt<=0, stay RUN.
//      ~active, cnt<IDLE_THRESH-1 -> cnt<=cnt+1.
//      ~active, cnt==IDLE_THRESH-1 -> OFF; clk_en_q and gclk_ready fall at that edge.
//    clk_en falls at the edge sampling the IDLE_THRESH-th consecutive idle cycle.
//    Any active cycle restarts the full count.
//  - OFF: clk_en_q=0, gclk_ready=0, cnt held 0.
//      active -> WAKE; clk_en_q<=1 at that edge, cnt<=0.
//  - WAKE: clk_en_q=1, gclk_ready=0.
//      cnt increments each edge.
//      At the edge where cnt==WAKE_DLY-1 -> RUN; gclk_ready<=1, cnt<=0.
//      The wake cannot be aborted: activity dropping in WAKE does not return to OFF.
//      Idle counting starts only in RUN.
//  - icg_force_on also ORs combinationally into clk_en.
//    The clock is on in the same cycle, before the state reaches WAKE.
//  - cfg_gate_en=0 forces active, so the block never leaves RUN and OFF exits on the next edge.
//  - Counter saturates and never wraps; cnt is reset only by an active cycle or a state change.
//  - clk_en_q is a flop output: glitch-free into the gate cell's low-phase latch.
//  - All outputs except the clk_en force path are registered.
// TESTING
//  1 IDLE_THRESH=8, release cpurst, busy_in=0, all else idle
//    -> clk_en and gclk_ready fall at the 8th rising edge; gate_state=01.
//  2 Idle 7 cycles, busy_in[2]=1 for 1 cycle, then idle
//    -> no gating at edge 8; clk_en falls 8 edges after the busy cycle.
//  3 In OFF, wake_req pulse 1 cycle, WAKE_DLY=2
//    -> clk_en=1 next edge, gate_state=10; gclk_ready=1 two edges later, gate_state=00.
//  4 In OFF, icg_force_on=1
//    -> clk_en=1 same cycle, combinationally; WAKE next edge; held RUN while forced.
//  5 cfg_gate_en=0, busy_in=0 for 100 cycles
//    -> clk_en=1, gclk_ready=1, gate_state=00 throughout.
//  6 Assert cpurst mid-WAKE, asynchronously between edges
//    -> clk_en=1, gclk_ready=1, gate_state=00 immediately; idle count restarts from 0.

Source files
------------

// File: rtl/gated_clk_en_ctrl.sv
// Idle-detect controller producing the CE input of a BUFGCE clock-gate cell.
// Watches the activity sources of one gated domain, drops the clock enable after
// a programmable run of idle cycles, and restarts the clock on any activity.
// gclk_ready tells requesters when the woken clock has had time to settle.
// Runs on the free-running clock, upstream of the gate cell.
module gated_clk_en_ctrl #(
    parameter int NUM_SRC     = 4,
    parameter int IDLE_CNT_W  = 4,
    parameter int IDLE_THRESH = 8,
    parameter int WAKE_DLY    = 2
) (
    input  logic               forever_cpuclk,
    input  logic               cpurst,
    input  logic [NUM_SRC-1:0] busy_in,
    input  logic               wake_req,
    input  logic               icg_force_on,
    input  logic               cfg_gate_en,
    output logic               clk_en,
    output logic               gclk_ready,
    output logic [1:0]         gate_state
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_OFF  = 2'b01,
        ST_WAKE = 2'b10
    } state_t;

    localparam logic [IDLE_CNT_W-1:0] IDLE_LAST = IDLE_CNT_W'(IDLE_THRESH - 1);
    localparam logic [IDLE_CNT_W-1:0] WAKE_LAST = IDLE_CNT_W'(WAKE_DLY - 1);
    localparam logic [IDLE_CNT_W-1:0] CNT_MAX   = {IDLE_CNT_W{1'b1}};

    state_t                state_q, state_n;
    logic [IDLE_CNT_W-1:0] cnt_q, cnt_n;
    logic                  clk_en_q, clk_en_n;
    logic                  ready_q, ready_n;
    logic                  active;

    // Counter increment that sticks at all-ones instead of wrapping
    function automatic logic [IDLE_CNT_W-1:0] sat_inc(input logic [IDLE_CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            return v;
        end
        return v + 1'b1;
    endfunction

    // Anything that needs the gated clock running counts as activity;
    // gating disabled is treated as permanent activity.
    assign active = (|busy_in) | wake_req | icg_force_on | ~cfg_gate_en;

    // Force path bypasses the flop so the clock is on within the same cycle
    assign clk_en     = clk_en_q | icg_force_on;
    assign gclk_ready = ready_q;
    assign gate_state = state_q;

    // Next-state, idle/wake counter and registered-output decode
    always_comb begin
        state_n  = state_q;
        cnt_n    = cnt_q;
        clk_en_n = clk_en_q;
        ready_n  = ready_q;
        unique case (state_q)
            ST_RUN: begin
                clk_en_n = 1'b1;
                ready_n  = 1'b1;
                if (active) begin
                    cnt_n = '0;
                end else if (cnt_q >= IDLE_LAST) begin
                    state_n  = ST_OFF;
                    cnt_n    = '0;
                    clk_en_n = 1'b0;
                    ready_n  = 1'b0;
                end else begin
                    cnt_n = sat_inc(cnt_q);
                end
            end
            ST_OFF: begin
                cnt_n    = '0;
                clk_en_n = 1'b0;
                ready_n  = 1'b0;
                if (active) begin
                    state_n  = ST_WAKE;
                    clk_en_n = 1'b1;
                end
            end
            ST_WAKE: begin
                // The wake always runs to completion so the domain never sees
                // a truncated clock burst.
                clk_en_n = 1'b1;
                ready_n  = 1'b0;
                if (cnt_q >= WAKE_LAST) begin
                    state_n = ST_RUN;
                    cnt_n   = '0;
                    ready_n = 1'b1;
                end else begin
                    cnt_n = sat_inc(cnt_q);
                end
            end
            default: begin
                state_n  = ST_RUN;
                cnt_n    = '0;
                clk_en_n = 1'b1;
                ready_n  = 1'b1;
            end
        endcase
    end

    // State, counter and output flops; the domain clocks out of reset
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            state_q  <= ST_RUN;
            cnt_q    <= '0;
            clk_en_q <= 1'b1;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_n;
            cnt_q    <= cnt_n;
            clk_en_q <= clk_en_n;
            ready_q  <= ready_n;
        end
    end

endmodule

// File: tb/tb_gated_clk_en_ctrl.sv
// Bench for gated_clk_en_ctrl: directed scenarios followed by random traffic,
// all checked against a behavioural model of the gating rules.
module tb_gated_clk_en_ctrl;

    localparam int NUM_SRC     = 4;
    localparam int IDLE_CNT_W  = 4;
    localparam int IDLE_THRESH = 8;
    localparam int WAKE_DLY    = 2;

    logic               clk;
    logic               rst;
    logic [NUM_SRC-1:0] busy_in;
    logic               wake_req;
    logic               icg_force_on;
    logic               cfg_gate_en;
    logic               clk_en;
    logic               gclk_ready;
    logic [1:0]         gate_state;

    int total;
    int bad;

    // Reference model: "gated" = clock stopped, "since_wake" = edges since the
    // wake began (-1 when not waking), "idle_run" = consecutive idle edges in run.
    bit m_gated;
    int m_since_wake;
    int m_idle_run;

    gated_clk_en_ctrl #(
        .NUM_SRC    (NUM_SRC),
        .IDLE_CNT_W (IDLE_CNT_W),
        .IDLE_THRESH(IDLE_THRESH),
        .WAKE_DLY   (WAKE_DLY)
    ) dut (
        .forever_cpuclk(clk),
        .cpurst        (rst),
        .busy_in       (busy_in),
        .wake_req      (wake_req),
        .icg_force_on  (icg_force_on),
        .cfg_gate_en   (cfg_gate_en),
        .clk_en        (clk_en),
        .gclk_ready    (gclk_ready),
        .gate_state    (gate_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_gated      = 1'b0;
        m_since_wake = -1;
        m_idle_run   = 0;
    endtask

    task automatic model_edge();
        bit act;
        act = (|busy_in) || wake_req || icg_force_on || !cfg_gate_en;
        if (m_since_wake >= 0) begin
            m_since_wake++;
            if (m_since_wake == WAKE_DLY) begin
                m_since_wake = -1;
                m_idle_run   = 0;
            end
        end else if (m_gated) begin
            if (act) begin
                m_gated      = 1'b0;
                m_since_wake = 0;
            end
        end else begin
            m_idle_run = act ? 0 : m_idle_run + 1;
            if (m_idle_run == IDLE_THRESH) begin
                m_gated    = 1'b1;
                m_idle_run = 0;
            end
        end
    endtask

    task automatic check1(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        logic       e_en;
        logic       e_rdy;
        logic [1:0] e_st;
        e_en  = !m_gated || icg_force_on;
        e_rdy = !m_gated && (m_since_wake < 0);
        e_st  = m_gated ? 2'b01 : ((m_since_wake >= 0) ? 2'b10 : 2'b00);
        check1({tag, ".clk_en"}, {1'b0, clk_en}, {1'b0, e_en});
        check1({tag, ".gclk_ready"}, {1'b0, gclk_ready}, {1'b0, e_rdy});
        check1({tag, ".gate_state"}, gate_state, e_st);
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        rst          = 1'b1;
        busy_in      = '0;
        wake_req     = 1'b0;
        icg_force_on = 1'b0;
        cfg_gate_en  = 1'b1;
        model_reset();

        // reset state
        #23;
        check_all("reset");
        #4;
        rst = 1'b0;

        // 1: pure idle gates at the 8th edge
        for (int i = 1; i <= IDLE_THRESH; i++) begin
            step("idle8");
        end
        check1("idle8.off_state", gate_state, 2'b01);
        check1("idle8.en_low", {1'b0, clk_en}, 2'b00);

        // 3: single-cycle wake pulse from OFF
        wake_req = 1'b1;
        step("wake.edge1");
        wake_req = 1'b0;
        check1("wake.state_wake", gate_state, 2'b10);
        check1("wake.en_high", {1'b0, clk_en}, 2'b01);
        step("wake.edge2");
        step("wake.edge3");
        check1("wake.ready", {1'b0, gclk_ready}, 2'b01);
        check1("wake.state_run", gate_state, 2'b00);

        // 2: idle 7, one busy cycle, then the full count restarts
        for (int i = 0; i < 7; i++) step("restart.pre");
        busy_in = 4'b0100;
        step("restart.busy");
        busy_in = '0;
        for (int i = 1; i < IDLE_THRESH; i++) step("restart.post");
        check1("restart.still_run", gate_state, 2'b00);
        step("restart.gate");
        check1("restart.gated", gate_state, 2'b01);

        // 4: scan force in OFF turns the clock on combinationally
        icg_force_on = 1'b1;
        #1;
        check1("force.comb_en", {1'b0, clk_en}, 2'b01);
        check1("force.still_off", gate_state, 2'b01);
        step("force.wake");
        check1("force.state_wake", gate_state, 2'b10);
        for (int i = 0; i < 12; i++) step("force.hold");
        check1("force.held_run", gate_state, 2'b00);
        icg_force_on = 1'b0;

        // 5: gating disabled keeps the domain running
        cfg_gate_en = 1'b0;
        for (int i = 0; i < 100; i++) step("nogate");
        cfg_gate_en = 1'b1;

        // 6: async reset in the middle of a wake
        for (int i = 0; i < IDLE_THRESH; i++) step("rstwake.idle");
        wake_req = 1'b1;
        step("rstwake.enter");
        wake_req = 1'b0;
        check1("rstwake.in_wake", gate_state, 2'b10);
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        check_all("rstwake.async");
        #2;
        rst = 1'b0;
        for (int i = 1; i <= IDLE_THRESH; i++) step("rstwake.recount");
        check1("rstwake.regated", gate_state, 2'b01);

        // random traffic, biased towards idle so gating actually happens
        for (int i = 0; i < 1500; i++) begin
            busy_in      = ($urandom_range(0, 9) == 0) ? NUM_SRC'($urandom) : '0;
            wake_req     = ($urandom_range(0, 24) == 0);
            icg_force_on = ($urandom_range(0, 39) == 0);
            cfg_gate_en  = ($urandom_range(0, 29) != 0);
            #1;
            check1("rand.comb_en", {1'b0, clk_en}, {1'b0, (!m_gated || icg_force_on)});
            step("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute safety net in case the clocked sequence ever stalls
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
